mem_arbiter: RTL

//   Two-master, one-slave memory arbiter between the core's fetch (IFU) and

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one memory port arbiter, round-robin, one
// transaction in flight, with an optional response timeout reported as err.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_data,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic              owner;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;
    logic              grant_ifu, grant_lsu;
    logic              timed_out;

    // owner/last_grant encoding: 0 = IFU, 1 = LSU
    always_comb begin
        state_n        = state;
        grant_ifu      = 1'b0;
        grant_lsu      = 1'b0;
        timed_out      = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                grant_lsu     = lsu_req_valid & (~ifu_req_valid | ~last_grant);
                grant_ifu     = ifu_req_valid & ~grant_lsu;
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu | grant_lsu) state_n = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_n = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_n = RESP;
                end else if (TIMEOUT != 0 && cnt_q == LIMIT) begin
                    timed_out = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP: begin
                ifu_resp_valid = ~owner;
                lsu_resp_valid = owner;
                if (owner ? lsu_resp_ready : ifu_resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_n;
            if (grant_ifu | grant_lsu) begin
                owner      <= grant_lsu;
                last_grant <= grant_lsu;
                addr_q     <= grant_lsu ? lsu_req_addr : ifu_req_addr;
                wen_q      <= grant_lsu & lsu_req_wen;
                wdata_q    <= grant_lsu ? lsu_req_wdata : '0;
                wmask_q    <= (grant_lsu & lsu_req_wen) ? lsu_req_wmask : '0;
            end
            if (state == REQ && mem_req_ready) cnt_q <= '0;
            if (state == WAIT) begin
                if (mem_resp_valid) begin
                    rdata_q <= wen_q ? '0 : mem_resp_rdata;
                    err_q   <= 1'b0;
                end else if (timed_out) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_data  = rdata_q;
    assign lsu_resp_rdata = rdata_q;
    assign ifu_resp_err   = ifu_resp_valid & err_q;
    assign lsu_resp_err   = lsu_resp_valid & err_q;

endmodule
